// File: rtl/rgb_seq_pkg.sv
// Shared types and register map for the RGB fade sequencer.
package rgb_seq_pkg;

    localparam int unsigned ADDR_W   = 3;
    localparam int unsigned CFG_W    = 24;
    localparam int unsigned PERIOD_W = 16;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FADE = 2'd1,
        ST_HOLD = 2'd2,
        ST_DONE = 2'd3
    } seq_state_t;

    // Register map: keyframes occupy the low addresses
    localparam logic [ADDR_W-1:0] ADDR_PERIOD = 3'd4;
    localparam logic [ADDR_W-1:0] ADDR_CTRL   = 3'd5;

    // Control register bit positions
    localparam int unsigned CTRL_START   = 0;
    localparam int unsigned CTRL_LOOP    = 1;
    localparam int unsigned CTRL_LAST_LO = 2;
    localparam int unsigned CTRL_LAST_HI = 3;
    localparam int unsigned CTRL_STOP    = 4;

    // A programmed period of zero behaves as one cycle per tick
    function automatic logic [PERIOD_W-1:0] eff_period(input logic [PERIOD_W-1:0] p);
        return (p == '0) ? PERIOD_W'(1) : p;
    endfunction

endpackage

// File: rtl/rgb_seq_tick.sv
// Programmable prescaler: one-cycle tick every eff_period(period) cycles.
// The period is sampled only on clear and on each reload, so a new value
// takes effect at the next reload.
module rgb_seq_tick
    import rgb_seq_pkg::*;
(
    input  logic                clk,
    input  logic                reset_n,
    input  logic                clr,
    input  logic [PERIOD_W-1:0] period,
    output logic                tick
);

    logic [PERIOD_W-1:0] cnt;
    logic [PERIOD_W-1:0] cur_period;

    // Count up to the latched period, pulse tick and reload on wrap
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt        <= '0;
            cur_period <= PERIOD_W'(1);
            tick       <= 1'b0;
        end else if (clr) begin
            cnt        <= '0;
            cur_period <= eff_period(period);
            tick       <= 1'b0;
        end else if (cnt >= cur_period - PERIOD_W'(1)) begin
            cnt        <= '0;
            cur_period <= eff_period(period);
            tick       <= 1'b1;
        end else begin
            cnt        <= cnt + PERIOD_W'(1);
            tick       <= 1'b0;
        end
    end

endmodule

// File: rtl/rgb_fade_sequencer.sv
// RGB keyframe fade sequencer: passes encoder levels through when idle,
// otherwise ramps the three duty levels between programmed keyframes.
module rgb_fade_sequencer
    import rgb_seq_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned NUM_KEYS   = 4,
    parameter int unsigned HOLD_TICKS = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] enc_level0,
    input  logic [WIDTH-1:0] enc_level1,
    input  logic [WIDTH-1:0] enc_level2,
    input  logic             cfg_we,
    input  logic [2:0]       cfg_addr,
    input  logic [23:0]      cfg_wdata,
    output logic             cfg_ack,
    output logic [WIDTH-1:0] level0,
    output logic [WIDTH-1:0] level1,
    output logic [WIDTH-1:0] level2,
    output logic             busy,
    output logic             done
);

    localparam int unsigned KW = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
    localparam int unsigned HW = $clog2(HOLD_TICKS + 1);

    seq_state_t          state;
    logic [CFG_W-1:0]    keys [NUM_KEYS];
    logic [PERIOD_W-1:0] period;
    logic                loop_q;
    logic [KW-1:0]       last_idx;
    logic [KW-1:0]       key_idx;
    logic [HW-1:0]       hold_cnt;
    logic                tick;

    logic                ctrl_wr_c;
    logic                stop_wr_c;
    logic                start_wr_c;
    logic                key_wr_c;
    logic                hold_end_c;
    logic                tick_clr_c;
    logic                at_target_c;
    logic [CFG_W-1:0]    cur_key_c;
    logic [WIDTH-1:0]    tgt0_c;
    logic [WIDTH-1:0]    tgt1_c;
    logic [WIDTH-1:0]    tgt2_c;

    // Move one code toward the target, never past it
    function automatic logic [WIDTH-1:0] step_toward(input logic [WIDTH-1:0] cur,
                                                     input logic [WIDTH-1:0] tgt);
        logic [WIDTH-1:0] nxt;
        nxt = cur;
        if (cur < tgt) begin
            nxt = cur + WIDTH'(1);
        end else if (cur > tgt) begin
            nxt = cur - WIDTH'(1);
        end
        return nxt;
    endfunction

    // Configuration write decode; stop wins over a simultaneous start
    assign ctrl_wr_c  = cfg_we && (cfg_addr == ADDR_CTRL);
    assign stop_wr_c  = ctrl_wr_c && cfg_wdata[CTRL_STOP];
    assign start_wr_c = ctrl_wr_c && cfg_wdata[CTRL_START] && !cfg_wdata[CTRL_STOP];
    assign key_wr_c   = cfg_we && (cfg_addr < ADDR_PERIOD) && (32'(cfg_addr) < NUM_KEYS);

    // Current target, read live so keyframe rewrites apply on the next compare
    assign cur_key_c   = keys[key_idx];
    assign tgt0_c      = WIDTH'(cur_key_c[23:16]);
    assign tgt1_c      = WIDTH'(cur_key_c[15:8]);
    assign tgt2_c      = WIDTH'(cur_key_c[7:0]);
    assign at_target_c = (level0 == tgt0_c) && (level1 == tgt1_c) && (level2 == tgt2_c);

    // Last tick of the hold interval
    assign hold_end_c = (state == ST_HOLD) && tick && (hold_cnt == HW'(HOLD_TICKS - 1));

    // Prescaler held clear while not sequencing and cleared on every FADE entry
    assign tick_clr_c = !((state == ST_FADE) || (state == ST_HOLD))
                        || start_wr_c || stop_wr_c || hold_end_c;

    rgb_seq_tick u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (tick_clr_c),
        .period  (period),
        .tick    (tick)
    );

    // Keyframe/period registers and write acknowledge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < NUM_KEYS; i++) begin
                keys[i] <= '0;
            end
            period  <= PERIOD_W'(1);
            cfg_ack <= 1'b0;
        end else begin
            cfg_ack <= cfg_we;
            if (key_wr_c) begin
                keys[cfg_addr[KW-1:0]] <= cfg_wdata;
            end
            if (cfg_we && (cfg_addr == ADDR_PERIOD)) begin
                period <= cfg_wdata[PERIOD_W-1:0];
            end
        end
    end

    // Sequencer FSM with registered levels, busy and done
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            level0   <= '0;
            level1   <= '0;
            level2   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            loop_q   <= 1'b0;
            last_idx <= '0;
            key_idx  <= '0;
            hold_cnt <= '0;
        end else begin
            done <= 1'b0;
            if (stop_wr_c) begin
                state <= ST_IDLE;
                busy  <= 1'b0;
            end else if (start_wr_c) begin
                state    <= ST_FADE;
                busy     <= 1'b1;
                loop_q   <= cfg_wdata[CTRL_LOOP];
                last_idx <= KW'(cfg_wdata[CTRL_LAST_HI:CTRL_LAST_LO]);
                key_idx  <= '0;
                hold_cnt <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        level0 <= enc_level0;
                        level1 <= enc_level1;
                        level2 <= enc_level2;
                        busy   <= 1'b0;
                    end
                    ST_FADE: begin
                        if (at_target_c) begin
                            state    <= ST_HOLD;
                            hold_cnt <= '0;
                        end else if (tick) begin
                            level0 <= step_toward(level0, tgt0_c);
                            level1 <= step_toward(level1, tgt1_c);
                            level2 <= step_toward(level2, tgt2_c);
                        end
                    end
                    ST_HOLD: begin
                        if (hold_end_c) begin
                            hold_cnt <= '0;
                            if (key_idx < last_idx) begin
                                key_idx <= key_idx + KW'(1);
                                state   <= ST_FADE;
                            end else if (loop_q) begin
                                key_idx <= '0;
                                state   <= ST_FADE;
                            end else begin
                                state <= ST_DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end
                        end else if (tick) begin
                            hold_cnt <= hold_cnt + HW'(1);
                        end
                    end
                    ST_DONE: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
